rr_arbiter: RTL and testbench

Round-robin arbiter granting one of CLIENTS requesters per cycle, with a registered one-hot grant. A rotating priority pointer guarantees that every continuously asserted request is granted within CLIENTS unstalled cycles. A stall input freezes arbitration. It sits between a set of requesting agents and a single shared resource.

---
 rtl/rr_arbiter.sv | 136 +++++++++++++
 tb/tb_rr_arbiter.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
//
// Round-robin arbiter. It grants one of CLIENTS requesters per cycle and
// drives a registered one-hot (or all-zero) grant. A rotating priority pointer
// names the highest-priority client. After a grant to client k, the pointer
// moves to k+1, so a request that stays high is served within CLIENTS
// unstalled cycles. While stall is high, no grant is issued and the pointer
// holds its value.
//
// Parameters
//   CLIENTS       number of requesters, 2..64
//
// Ports
//   clock         rising-edge clock for all state
//   reset         synchronous, active-high reset (grant = 0, ptr = 0)
//   request       [CLIENTS-1:0] bit i high = client i requests
//   stall         high = no grant this cycle, pointer held
//   grant         [CLIENTS-1:0] registered grant, one-hot or zero
//
// Optional feature (macro RR_ARBITER_GRANT_IDX_EN)
//   grant_valid   registered |grant
//   grant_index   registered binary index of the granted client, 0 when idle
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int CLIENTS = 32
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [CLIENTS-1:0]         request,
    input  logic                       stall,
`ifdef RR_ARBITER_GRANT_IDX_EN
    output logic                       grant_valid,
    output logic [$clog2(CLIENTS)-1:0] grant_index,
`endif
    output logic [CLIENTS-1:0]         grant
);

    localparam int PW = $clog2(CLIENTS);

    logic [PW-1:0]      ptr_q;
    logic [PW-1:0]      ptr_d;
    logic [CLIENTS-1:0] grant_q;
    logic [CLIENTS-1:0] grant_d;

    // upper_mask[i] is set for every client at or above the pointer. The
    // search first looks at requests in that region. If none are set there,
    // it wraps around to the lowest requester overall.
    logic [CLIENTS-1:0] upper_mask;
    logic [CLIENTS-1:0] masked_req;

    genvar gi;
    generate
        for (gi = 0; gi < CLIENTS; gi++) begin : g_mask
            localparam logic [6:0] IDX = 7'(gi);
            assign upper_mask[gi] = ({{(7-PW){1'b0}}, ptr_q} <= IDX);
        end
    endgenerate

    assign masked_req = request & upper_mask;

    logic          hi_found;
    logic [PW-1:0] hi_idx;
    logic [PW-1:0] lo_idx;
    logic [PW-1:0] winner;
    logic          any_req;
    logic          issue;

    // Lowest set bit of the masked and unmasked request vectors. The loop
    // scans downwards, so the last match it records is the lowest index.
    always_comb begin
        hi_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = CLIENTS - 1; i >= 0; i--) begin
            if (masked_req[i]) begin
                hi_found = 1'b1;
                hi_idx   = PW'(i);
            end
            if (request[i]) begin
                lo_idx = PW'(i);
            end
        end
    end

    assign any_req = |request;
    assign winner  = hi_found ? hi_idx : lo_idx;
    assign issue   = any_req && !stall;

    always_comb begin
        grant_d = '0;
        ptr_d   = ptr_q;
        if (issue) begin
            grant_d[winner] = 1'b1;
            ptr_d = (winner == PW'(CLIENTS - 1)) ? '0 : winner + PW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            grant_q <= '0;
            ptr_q   <= '0;
        end else begin
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
        end
    end

    assign grant = grant_q;

`ifdef RR_ARBITER_GRANT_IDX_EN
    logic          grant_valid_q;
    logic          grant_valid_d;
    logic [PW-1:0] grant_index_q;
    logic [PW-1:0] grant_index_d;

    always_comb begin
        grant_valid_d = issue;
        grant_index_d = issue ? winner : '0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            grant_valid_q <= 1'b0;
            grant_index_q <= '0;
        end else begin
            grant_valid_q <= grant_valid_d;
            grant_index_q <= grant_index_d;
        end
    end

    assign grant_valid = grant_valid_q;
    assign grant_index = grant_index_q;
`endif

endmodule

// File: tb/tb_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rr_arbiter
//
// Directed bench for rr_arbiter with CLIENTS = 32. Each check states its
// expected grant by hand. The pointer position is tracked by reasoning from
// the preceding grants. The fairness section drives random competitors and
// checks three properties: grant is one-hot or zero, no grant goes to a
// client that is not requesting, and client 4 waits at most 31 cycles.
// -----------------------------------------------------------------------------
module tb_rr_arbiter;

    localparam int CLIENTS = 32;

    logic               clock;
    logic               reset;
    logic [CLIENTS-1:0] request;
    logic               stall;
    logic [CLIENTS-1:0] grant;
`ifdef RR_ARBITER_GRANT_IDX_EN
    logic               grant_valid;
    logic [4:0]         grant_index;
`endif

    int total;
    int bad;

    rr_arbiter #(.CLIENTS(CLIENTS)) dut (
        .clock       (clock),
        .reset       (reset),
        .request     (request),
        .stall       (stall),
`ifdef RR_ARBITER_GRANT_IDX_EN
        .grant_valid (grant_valid),
        .grant_index (grant_index),
`endif
        .grant       (grant)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end else begin
            $display("ok   %s: %h", tag, obs);
        end
    endtask

    // Advance one clock edge. Outputs are then sampled 1 time unit later.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Step once and compare grant against the expected value. When the
    // index outputs are built in, compare those as well.
    task automatic step_check(input string tag, input logic [31:0] exp);
        step();
        check(tag, grant, exp);
`ifdef RR_ARBITER_GRANT_IDX_EN
        check({tag, "_vld"}, 32'(grant_valid), 32'(exp != 0));
        check({tag, "_idx"}, 32'(grant_index), (exp == 0) ? 32'd0 : 32'($clog2(exp)));
`endif
    endtask

    initial begin
        logic [31:0] req_now;
        int          gap;

        total   = 0;
        bad     = 0;
        reset   = 1'b1;
        stall   = 1'b0;
        request = '1;

        // Reset held for 2 cycles with every client requesting.
        step_check("rst0", 32'h0);
        step_check("rst1", 32'h0);

        // Release reset. grant walks 0,1,...,31,0,... one client per cycle.
        reset = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step_check($sformatf("walk%0d", i), 32'h1 << (i % 32));
        end

        // Skip check, starting from ptr = 0.
        reset = 1'b1;
        step_check("rst_skip", 32'h0);
        reset   = 1'b0;
        request = 32'h0000_0006;
        step_check("skip_g1", 32'h0000_0002);        // ptr -> 2
        step_check("skip_g2", 32'h0000_0004);        // ptr -> 3
        request = 32'h0000_000E;
        step_check("skip_g3", 32'h0000_0008);        // ptr -> 4
        request = 32'h0000_000C;
        step_check("skip_wrap_g2", 32'h0000_0004);   // ptr 4 wraps to 2, ptr -> 3

        // Stall: clients 3 and 4 request while stalled. After the stall
        // ends, client 3 wins first, which shows the pointer held at 3.
        request = 32'h0000_0018;
        stall   = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step_check($sformatf("stall%0d", i), 32'h0);
        end
        stall = 1'b0;
        step_check("post_stall_g3", 32'h0000_0008);  // ptr -> 4
        step_check("post_stall_g4", 32'h0000_0010);  // ptr -> 5

        // Idle does not move the pointer.
        request = 32'h0;
        step_check("idle", 32'h0);
        request = 32'h0000_0041;
        step_check("after_idle_g6", 32'h0000_0040);  // ptr 5 -> picks 6

        // Wrap: reach ptr = 31, then alternate clients 31 and 0.
        reset = 1'b1;
        step_check("rst_wrap", 32'h0);
        reset   = 1'b0;
        request = 32'h4000_0000;
        step_check("wrap_g30", 32'h4000_0000);       // ptr -> 31
        request = 32'h8000_0001;
        step_check("wrap_g31", 32'h8000_0000);       // ptr -> 0
        step_check("wrap_g0", 32'h0000_0001);        // ptr -> 1
        step_check("wrap_g31b", 32'h8000_0000);      // ptr -> 0

        // Reset in the middle of operation takes priority over requests.
        request = '1;
        step_check("mid_run", 32'h0000_0001);        // ptr 0 -> grant 0
        reset = 1'b1;
        step_check("mid_rst", 32'h0);
        reset = 1'b0;
        step_check("after_mid_rst", 32'h0000_0001);

        // A sole requester is granted every cycle.
        request = 32'h0000_0200;
        for (int i = 0; i < 4; i++) begin
            step_check($sformatf("sole%0d", i), 32'h0000_0200);
        end

        // Fairness: client 4 requests permanently, other clients at random.
        gap = 0;
        for (int i = 0; i < 160; i++) begin
            req_now = $urandom | 32'h0000_0010;
            request = req_now;
            step();
            check($sformatf("fair_onehot%0d", i), 32'($onehot0(grant)), 32'd1);
            check($sformatf("fair_legal%0d", i), grant & ~req_now, 32'h0);
            if (grant[4]) gap = 0;
            else          gap++;
            check($sformatf("fair_gap%0d", i), 32'(gap > 31), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
